// File: rtl/id_exe_skid_reg_if.sv
// rtl/id_exe_skid_reg_if.sv - ID/EXE handshake and payload bundle
interface id_exe_skid_reg_if #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5,
  parameter int EXE_W  = 4,
  parameter int M_W    = 3,
  parameter int WB_W   = 2
);
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [DATA_W-1:0] signExIn;
  logic [DATA_W-1:0] readData1In;
  logic [DATA_W-1:0] readData2In;
  logic [DATA_W-1:0] PC_In;
  logic [EXE_W-1:0]  EXE_In;
  logic [M_W-1:0]    M_In;
  logic [WB_W-1:0]   WB_In;
  logic [DEST_W-1:0] dest1In;
  logic [DEST_W-1:0] dest2In;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] signExOut;
  logic [DATA_W-1:0] readData1Out;
  logic [DATA_W-1:0] readData2Out;
  logic [DATA_W-1:0] PC_Out;
  logic [EXE_W-1:0]  EXE_Out;
  logic [M_W-1:0]    M_Out;
  logic [WB_W-1:0]   WB_Out;
  logic [DEST_W-1:0] dest1Out;
  logic [DEST_W-1:0] dest2Out;
  logic [1:0]        occupancy;

  modport slave (
    input  in_valid, flush, signExIn, readData1In, readData2In, PC_In,
           EXE_In, M_In, WB_In, dest1In, dest2In, out_ready,
    output in_ready, out_valid, signExOut, readData1Out, readData2Out, PC_Out,
           EXE_Out, M_Out, WB_Out, dest1Out, dest2Out, occupancy
  );

  modport master (
    output in_valid, flush, signExIn, readData1In, readData2In, PC_In,
           EXE_In, M_In, WB_In, dest1In, dest2In, out_ready,
    input  in_ready, out_valid, signExOut, readData1Out, readData2Out, PC_Out,
           EXE_Out, M_Out, WB_Out, dest1Out, dest2Out, occupancy
  );
endinterface

// File: rtl/id_exe_skid_reg.sv
// rtl/id_exe_skid_reg.sv - ID/EXE pipeline register with a one-deep skid entry
// in_ready is taken purely from the skid valid flop so upstream never sees a comb path.
module id_exe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5,
  parameter int EXE_W  = 4,
  parameter int M_W    = 3,
  parameter int WB_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  id_exe_skid_reg_if.slave bus
);

  typedef struct packed {
    logic [DATA_W-1:0] sign_ex;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] pc;
    logic [EXE_W-1:0]  exe;
    logic [M_W-1:0]    m;
    logic [WB_W-1:0]   wb;
    logic [DEST_W-1:0] dest1;
    logic [DEST_W-1:0] dest2;
  } entry_t;

  entry_t main_q, skid_q, main_d, skid_d, in_entry;
  logic   main_v, skid_v, main_v_d, skid_v_d;
  logic   accept, drain;

  always_comb begin
    in_entry            = '0;
    in_entry.sign_ex    = bus.signExIn;
    in_entry.read_data1 = bus.readData1In;
    in_entry.read_data2 = bus.readData2In;
    in_entry.pc         = bus.PC_In;
    in_entry.exe        = bus.EXE_In;
    in_entry.m          = bus.M_In;
    in_entry.wb         = bus.WB_In;
    in_entry.dest1      = bus.dest1In;
    in_entry.dest2      = bus.dest2In;
  end

  assign accept = bus.in_valid & ~skid_v;
  assign drain  = main_v & bus.out_ready;

  // Flush only kills valid bits; payload stays put so data outputs never glitch.
  always_comb begin
    main_v_d = main_v;
    skid_v_d = skid_v;
    main_d   = main_q;
    skid_d   = skid_q;
    if (bus.flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v) begin
      if (accept) begin
        main_d   = in_entry;
        main_v_d = 1'b1;
      end
    end else if (drain) begin
      if (skid_v) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else if (accept) begin
        main_d = in_entry;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (!skid_v && accept) begin
      skid_d   = in_entry;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_v <= main_v_d;
      skid_v <= skid_v_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign bus.in_ready     = ~skid_v;
  assign bus.out_valid    = main_v;
  assign bus.occupancy    = {1'b0, main_v} + {1'b0, skid_v};

  assign bus.signExOut    = main_q.sign_ex;
  assign bus.readData1Out = main_q.read_data1;
  assign bus.readData2Out = main_q.read_data2;
  assign bus.PC_Out       = main_q.pc;
  assign bus.dest1Out     = main_q.dest1;
  assign bus.dest2Out     = main_q.dest2;

  // Control fields read as a NOP whenever the stage holds a bubble.
  assign bus.EXE_Out      = main_v ? main_q.exe : '0;
  assign bus.M_Out        = main_v ? main_q.m   : '0;
  assign bus.WB_Out       = main_v ? main_q.wb  : '0;

endmodule

// File: doc/id_exe_skid_reg.md
ID_EXE_SKID_REG -- requirements
Module: id_exe_skid_reg

Interface
REQ-001 Parameters: DATA_W, default 32, width of signEx/readData1/readData2/PC fields.
REQ-002 Parameters: DEST_W, default 5, width of each destination register index.
REQ-003 Parameters: EXE_W, default 4; M_W, default 3; WB_W, default 2, widths of the EXE, M and WB control fields.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  ID stage presents a valid instruction.
REQ-007 in_ready  out  1  stage can accept; driven only from registered state.
REQ-008 flush  in  1  synchronous kill of all held instructions (branch/exception).
REQ-009 signExIn, readData1In, readData2In, PC_In  in  DATA_W each  ID payload.
REQ-010 EXE_In  in  EXE_W; M_In  in  M_W; WB_In  in  WB_W  control payload.
REQ-011 dest1In, dest2In  in  DEST_W each  candidate destinations.
REQ-012 out_valid  out  1  EXE stage payload valid.
REQ-013 out_ready  in  1  EXE stage consumes payload this cycle.
REQ-014 signExOut, readData1Out, readData2Out, PC_Out, EXE_Out, M_Out, WB_Out, dest1Out, dest2Out  out  widths matching inputs  registered payload.
REQ-015 occupancy  out  2  number of held entries, 0..2.

Function
REQ-016 Storage: one main entry driving outputs plus one skid entry; each has a valid bit; skid valid SHALL imply main valid.
REQ-017 accept = in_valid & in_ready; drain = out_valid & out_ready.
REQ-018 in_ready SHALL equal NOT skid valid; no combinational path from out_ready or in_valid to in_ready.
REQ-019 out_valid SHALL equal main valid; occupancy = main valid + skid valid.
REQ-020 Main empty, accept: main loads input next edge.
REQ-021 Main full, drain, skid empty: accept loads input into main; no accept empties main.
REQ-022 Main full, drain, skid full: main loads skid contents; skid empties.
REQ-023 Main full, no drain, skid empty: accept loads input into skid; main holds.
REQ-024 Main full, no drain, skid full: all state holds.
REQ-025 Latency in_valid to out_valid: 1 cycle; sustained throughput 1 instruction/cycle when out_ready held high.
REQ-026 Order SHALL be preserved: instructions leave in acceptance order; none duplicated or dropped except by flush.
REQ-027 flush has priority over all other events: next edge clears main and skid valid; input presented in the flush cycle is discarded even if in_ready=1.
REQ-028 Whenever main valid is 0, EXE_Out, M_Out, WB_Out SHALL be 0 (bubble is a NOP downstream); data and dest outputs are don't-care but SHALL not change X-free values to X.
REQ-029 Payload outputs SHALL change only on a main load; held entries SHALL be bit-stable while out_valid=1 and out_ready=0.
REQ-030 Simultaneous drain and accept with occupancy 1 SHALL keep occupancy 1 with new payload at outputs.

Reset
REQ-031 rst low asynchronously clears both valid bits and all payload registers to 0: out_valid=0, in_ready=1, occupancy=0, all payload outputs 0.
REQ-032 Release of rst is synchronous to clk; first accept possible on the first rising edge with rst high.
REQ-033 Reset asserted mid-operation discards all held entries with no partial output.

Verification
REQ-034 Reset then in_valid=1, PC_In=0x00000040, EXE_In=0x5, out_ready=1 -> next cycle out_valid=1, PC_Out=0x40, EXE_Out=0x5, occupancy=1.
REQ-035 Stream PC 0x0,0x4,0x8,0xC with out_ready=1 -> outputs same sequence, one per cycle, in_ready constant 1.
REQ-036 out_ready=0 while feeding 0x10,0x14 -> occupancy 2, in_ready=0, PC_Out=0x10 held; raise out_ready -> 0x10 then 0x14 emitted, no loss.
REQ-037 Occupancy 2, flush=1 with in_valid=1 PC_In=0x20 -> next cycle out_valid=0, occupancy=0, EXE_Out=M_Out=WB_Out=0, 0x20 never emitted.
REQ-038 rst driven low between clock edges with occupancy 2 -> out_valid=0, in_ready=1, all outputs 0 immediately, without waiting for clk.
REQ-039 Random in_valid/out_ready/flush for 10000 cycles against a scoreboard model -> order preserved, no duplication, REQ-016 invariant never violated.
